// File: rtl/fpu_except_pkg.sv
// Shared types and constants for the FPU exception/result-select stage.
package fpu_except_pkg;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    MUL = 3'b010,
    DIV = 3'b011
  } fpu_op_e;

  typedef struct packed {
    logic inv;
    logic dz;
    logic ovf;
    logic unf;
    logic ine;
  } fpu_flags_t;

  typedef struct packed {
    logic [31:0] result;
    fpu_flags_t  flags;
  } res_entry_t;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_ONES = 8'hFF;
  localparam logic [7:0]  EXP_ZERO = 8'h00;

  function automatic logic [31:0] signed_inf(input logic sign);
    return {sign, EXP_ONES, 23'h0};
  endfunction

endpackage

// File: rtl/except_res_fifo.sv
// DEPTH-entry synchronous FIFO holding selected results and their exception flags.
module except_res_fifo
  import fpu_except_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  res_entry_t data_i,
  output logic       ready_o,
  input  logic       pop_i,
  output logic       valid_o,
  output res_entry_t head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] Full = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  res_entry_t    mem_q [DEPTH];
  logic          push_en, pop_en;

  assign ready_o = (count_q < Full);
  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_en = push_i & ready_o;
  assign pop_en  = pop_i & valid_o;

  always_comb begin
    count_d = count_q;
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the output reads zero while empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (push_en) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_en) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

endmodule

// File: rtl/except_result_sel.sv
// Final IEEE-754 single result/flag selection with an output FIFO.
// Define EXCEPT_RES_FTZ_EN to flush denormal operands and results to zero.
module except_result_sel
  import fpu_except_pkg::*;
#(
  parameter logic [31:0] QNAN_DEFAULT = QNAN,
  parameter int unsigned DEPTH        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fpu_op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic [31:0] norm_result,
  input  logic        norm_ovf,
  input  logic        norm_unf,
  input  logic        norm_ine,
  input  logic        inf,
  input  logic        ind,
  input  logic        qnan,
  input  logic        snan,
  input  logic        opa_nan,
  input  logic        opb_nan,
  input  logic        opa_00,
  input  logic        opb_00,
  input  logic        opa_inf,
  input  logic        opb_inf,
  input  logic        opa_dn,
  input  logic        opb_dn,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flg_inv,
  output logic        flg_dz,
  output logic        flg_ovf,
  output logic        flg_unf,
  output logic        flg_ine
);

  fpu_op_e    op;
  res_entry_t sel, head;
  logic       is_addsub, is_mul, is_div, is_rsvd;
  logic       a_zero, b_zero, eff_sign_b, sign_xor, invalid;
  logic       unused_cls;

  assign op         = fpu_op_e'(fpu_op);
  assign is_addsub  = (op == ADD) | (op == SUB);
  assign is_mul     = (op == MUL);
  assign is_div     = (op == DIV);
  assign is_rsvd    = fpu_op[2];
  assign eff_sign_b = opb[31] ^ (op == SUB);
  assign sign_xor   = opa[31] ^ opb[31];
  // qnan is implied by the per-operand NaN flags.
  assign unused_cls = qnan;

`ifdef EXCEPT_RES_FTZ_EN
  assign a_zero = opa_00 | opa_dn;
  assign b_zero = opb_00 | opb_dn;
`else
  logic unused_dn;
  assign unused_dn = opa_dn ^ opb_dn;
  assign a_zero    = opa_00;
  assign b_zero    = opb_00;
`endif

  assign invalid = (is_addsub & ind & (opa[31] != eff_sign_b))
                 | (is_mul & ((a_zero & opb_inf) | (b_zero & opa_inf)))
                 | (is_div & ((a_zero & b_zero) | ind))
                 | is_rsvd;

  always_comb begin
    sel = '0;
    if (opa_nan | opb_nan) begin
      sel.result    = opa_nan ? (opa | 32'h0040_0000) : (opb | 32'h0040_0000);
      sel.flags.inv = snan;
    end else if (invalid) begin
      sel.result    = QNAN_DEFAULT;
      sel.flags.inv = 1'b1;
    end else if (is_div & b_zero & ~opa_inf) begin
      sel.result   = signed_inf(sign_xor);
      sel.flags.dz = 1'b1;
    end else if (inf) begin
      if (is_addsub) begin
        sel.result = signed_inf(opa_inf ? opa[31] : eff_sign_b);
      end else if (is_div & opb_inf & ~opa_inf) begin
        sel.result = {sign_xor, 31'h0};
      end else begin
        sel.result = signed_inf(sign_xor);
      end
    end else begin
      sel.result    = norm_result;
      sel.flags.ovf = norm_ovf;
      sel.flags.unf = norm_unf;
      sel.flags.ine = norm_ine;
`ifdef EXCEPT_RES_FTZ_EN
      if ((norm_result[30:23] == EXP_ZERO) && (norm_result[22:0] != 23'h0)) begin
        sel.result    = {norm_result[31], 31'h0};
        sel.flags.unf = 1'b1;
        sel.flags.ine = 1'b1;
      end
`endif
    end
  end

  except_res_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (in_valid),
    .data_i  (sel),
    .ready_o (in_ready),
    .pop_i   (out_ready),
    .valid_o (out_valid),
    .head_o  (head)
  );

  assign result  = head.result;
  assign flg_inv = head.flags.inv;
  assign flg_dz  = head.flags.dz;
  assign flg_ovf = head.flags.ovf;
  assign flg_unf = head.flags.unf;
  assign flg_ine = head.flags.ine;

endmodule

// File: tb/tb_except_result_sel.sv
// Self-checking bench for except_result_sel: vector table plus scoreboard queue.
module tb_except_result_sel;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  fpu_op;
  logic [31:0] opa, opb, norm_result, result;
  logic        norm_ovf, norm_unf, norm_ine;
  logic        inf, ind, qnan, snan, opa_nan, opb_nan, opa_00, opb_00;
  logic        opa_inf, opb_inf, opa_dn, opb_dn;
  logic        flg_inv, flg_dz, flg_ovf, flg_unf, flg_ine;

  always #5 clk = ~clk;

  except_result_sel dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .fpu_op(fpu_op),
    .opa(opa), .opb(opb), .norm_result(norm_result), .norm_ovf(norm_ovf),
    .norm_unf(norm_unf), .norm_ine(norm_ine), .inf(inf), .ind(ind), .qnan(qnan),
    .snan(snan), .opa_nan(opa_nan), .opb_nan(opb_nan), .opa_00(opa_00), .opb_00(opb_00),
    .opa_inf(opa_inf), .opb_inf(opb_inf), .opa_dn(opa_dn), .opb_dn(opb_dn),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flg_inv(flg_inv),
    .flg_dz(flg_dz), .flg_ovf(flg_ovf), .flg_unf(flg_unf), .flg_ine(flg_ine)
  );

  // Classifier bits: {inf,ind,qnan,snan,opa_nan,opb_nan,opa_00,opb_00,opa_inf,opb_inf,opa_dn,opb_dn}
  localparam logic [11:0] CInf = 12'h800, CInd = 12'h400, CQnan = 12'h200, CSnan = 12'h100;
  localparam logic [11:0] CANan = 12'h080, CBNan = 12'h040, CA00 = 12'h020, CB00 = 12'h010;
  localparam logic [11:0] CAInf = 12'h008, CBInf = 12'h004, CADn = 12'h002, CBDn = 12'h001;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, norm;
    logic [2:0]  nflg;     // {ovf,unf,ine}
    logic [11:0] cls;
    logic [31:0] exp_res;
    logic [4:0]  exp_flg;  // {inv,dz,ovf,unf,ine}
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  exp_t        cur_exp;
  int          total = 0;
  int          bad = 0;
  int          pushes = 0;
  int          pops = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] norm, input logic [2:0] nflg,
                              input logic [11:0] cls, input logic [31:0] er,
                              input logic [4:0] ef);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.norm = norm; v.nflg = nflg; v.cls = cls;
    v.exp_res = er; v.exp_flg = ef;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    fpu_op = v.op; opa = v.a; opb = v.b; norm_result = v.norm;
    {norm_ovf, norm_unf, norm_ine} = v.nflg;
    {inf, ind, qnan, snan, opa_nan, opb_nan, opa_00, opb_00, opa_inf, opb_inf, opa_dn,
     opb_dn} = v.cls;
    cur_exp.res = v.exp_res;
    cur_exp.flg = v.exp_flg;
  endtask

  // Drive at posedge+1; acceptance is judged on the following negedge.
  task automatic send(input vec_t v);
    bit ok;
    apply(v);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);
    chk("drain_out_valid", 64'(out_valid), 64'd0);
  endtask

  // Scoreboard: compare on pop, then record a newly accepted bundle.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", 64'(result), 64'(e.res));
          chk("flags", 64'({flg_inv, flg_dz, flg_ovf, flg_unf, flg_ine}), 64'(e.flg));
          pops++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(cur_exp);
        pushes++;
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    apply(mk(3'b000, 0, 0, 0, 3'b000, 12'h000, 0, 5'b0));

    // Add/sub
    vecs.push_back(mk(3'b001, 32'h7F800000, 32'h7F800000, 0, 3'b000,
                      CInf | CInd | CAInf | CBInf, 32'h7FC00000, 5'b10000));
    vecs.push_back(mk(3'b000, 32'h7F800000, 32'h7F800000, 0, 3'b000,
                      CInf | CInd | CAInf | CBInf, 32'h7F800000, 5'b00000));
    vecs.push_back(mk(3'b000, 32'hFF800000, 32'h3F800000, 0, 3'b000,
                      CInf | CAInf, 32'hFF800000, 5'b00000));
    vecs.push_back(mk(3'b001, 32'h3F800000, 32'h7F800000, 0, 3'b000,
                      CInf | CBInf, 32'hFF800000, 5'b00000));
    vecs.push_back(mk(3'b000, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b001,
                      12'h000, 32'h40400000, 5'b00001));
    // Mul
    vecs.push_back(mk(3'b010, 32'h00000000, 32'hFF800000, 0, 3'b000,
                      CInf | CA00 | CBInf, 32'h7FC00000, 5'b10000));
    vecs.push_back(mk(3'b010, 32'h3F800000, 32'hFF800000, 0, 3'b000,
                      CInf | CBInf, 32'hFF800000, 5'b00000));
    vecs.push_back(mk(3'b010, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b101,
                      12'h000, 32'h7F800000, 5'b00101));
    // Div: -2/0 gives -inf from the xor of operand signs
    vecs.push_back(mk(3'b011, 32'hC0000000, 32'h00000000, 0, 3'b000,
                      CB00, 32'hFF800000, 5'b01000));
    vecs.push_back(mk(3'b011, 32'h00000000, 32'h00000000, 0, 3'b000,
                      CA00 | CB00, 32'h7FC00000, 5'b10000));
    vecs.push_back(mk(3'b011, 32'h7F800000, 32'h00000000, 0, 3'b000,
                      CInf | CAInf | CB00, 32'h7F800000, 5'b00000));
    vecs.push_back(mk(3'b011, 32'h3F800000, 32'hFF800000, 0, 3'b000,
                      CInf | CBInf, 32'h80000000, 5'b00000));
    vecs.push_back(mk(3'b011, 32'hFF800000, 32'h40000000, 0, 3'b000,
                      CInf | CAInf, 32'hFF800000, 5'b00000));
    vecs.push_back(mk(3'b011, 32'h7F800000, 32'hFF800000, 0, 3'b000,
                      CInf | CInd | CAInf | CBInf, 32'h7FC00000, 5'b10000));
    // NaNs and reserved opcode
    vecs.push_back(mk(3'b000, 32'h7F800001, 32'h3F800000, 0, 3'b000,
                      CSnan | CANan, 32'h7FC00001, 5'b10000));
    vecs.push_back(mk(3'b010, 32'h3F800000, 32'hFFC00005, 0, 3'b000,
                      CQnan | CBNan, 32'hFFC00005, 5'b00000));
    vecs.push_back(mk(3'b101, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000,
                      12'h000, 32'h7FC00000, 5'b10000));
`ifdef EXCEPT_RES_FTZ_EN
    vecs.push_back(mk(3'b000, 32'h80000001, 32'h00000000, 32'h80000001, 3'b001,
                      CA00 | CB00, 32'h80000000, 5'b00011));
    vecs.push_back(mk(3'b010, 32'h00000001, 32'hFF800000, 0, 3'b000,
                      CInf | CADn | CBInf, 32'h7FC00000, 5'b10000));
`else
    vecs.push_back(mk(3'b000, 32'h80000001, 32'h00000000, 32'h80000001, 3'b001,
                      CA00 | CB00, 32'h80000001, 5'b00001));
    vecs.push_back(mk(3'b010, 32'h00000001, 32'hFF800000, 0, 3'b000,
                      CInf | CADn | CBInf, 32'hFF800000, 5'b00000));
`endif

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({flg_inv, flg_dz, flg_ovf, flg_unf, flg_ine}), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Latency: out_valid one cycle after a lone accept
    send(vecs[0]);
    chk("latency_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    chk("latency_result", 64'(result), 64'h7FC00000);
    out_ready = 1'b1;
    drain();

    // Streamed table at full throughput
    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) send(vecs[i]);
    drain();

    // Backpressure: two fill the FIFO, third is held
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(vecs[5]);
    send(vecs[6]);
    apply(vecs[8]);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_head", 64'(result), 64'(vecs[5].exp_res));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        if (in_ready) ok = 1'b1;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      if (!ok) chk("held_accept_timeout", 64'd0, 64'd1);
    end
    drain();
    chk("push_pop_balance", 64'(pops), 64'(pushes));

    // Reset with two entries queued
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(vecs[1]);
    send(vecs[2]);
    @(negedge clk);
    chk("queued_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_result", 64'(result), 64'd0);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
